perm_ctrl: RTL and testbench

PERM_CTRL -- requirements
Module: perm_ctrl

---
 rtl/ascon_pack.sv | 29 ++
 rtl/round_counter.sv | 24 ++
 rtl/perm_ctrl.sv | 78 +++++++
 tb/tb_perm_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state layout, round constants, permutation mode
// encoding, control FSM states and per-mode round counts.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam logic [7:0] round_constant [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [1:0] {
    MODE_P12     = 2'b00,
    MODE_P6      = 2'b01,
    MODE_P8      = 2'b10,
    MODE_ILLEGAL = 2'b11
  } type_perm_mode;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ROUND = 2'b01,
    ST_DONE  = 2'b10
  } type_fsm_state;

  localparam logic [3:0] ROUNDS_P12 = 4'd12;
  localparam logic [3:0] ROUNDS_P6  = 4'd6;
  localparam logic [3:0] ROUNDS_P8  = 4'd8;

endpackage

// File: rtl/round_counter.sv
// Round-constant index counter: loads the first index of a permutation and
// steps up to ROUNDS_MAX-1, where it saturates and flags the last round.
module round_counter #(
  parameter int ROUNDS_MAX = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] count,
  output logic       last
);

  assign last = (count == 4'(ROUNDS_MAX - 1));

  // Increment is gated by last so the counter can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count <= '0;
    else if (load)         count <= load_val;
    else if (inc && !last) count <= count + 4'd1;
  end

endmodule

// File: rtl/perm_ctrl.sv
// ASCON permutation controller: sequences p12/p6 (and p8 when ASCON_P8_EN is
// defined) round indices and drives the state-register mux and write enable.
module perm_ctrl
  import ascon_pack::*;
#(
  parameter int ROUNDS_MAX = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       en_reg_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  type_fsm_state state;
  logic          legal;
  logic [3:0]    n_rounds;
  logic          accept;
  logic          first;
  logic          err;
  logic [3:0]    count;
  logic          last;

  always_comb begin
    legal    = 1'b0;
    n_rounds = '0;
    case (type_perm_mode'(mode_i))
      MODE_P12: begin legal = 1'b1; n_rounds = ROUNDS_P12; end
      MODE_P6:  begin legal = 1'b1; n_rounds = ROUNDS_P6;  end
`ifdef ASCON_P8_EN
      MODE_P8:  begin legal = 1'b1; n_rounds = ROUNDS_P8;  end
`endif
      default:  begin legal = 1'b0; n_rounds = '0; end
    endcase
  end

  assign accept = (state == ST_IDLE) && start_i && legal;

  round_counter #(.ROUNDS_MAX(ROUNDS_MAX)) u_round_counter (
    .clk      (clock_i),
    .rst      (reset_i),
    .load     (accept),
    .load_val (4'(ROUNDS_MAX) - n_rounds),
    .inc      (state == ST_ROUND),
    .count    (count),
    .last     (last)
  );

  // first marks the cycle right after acceptance, when the external state is muxed in.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      first <= 1'b0;
      err   <= 1'b0;
    end else begin
      first <= accept;
      err   <= (state == ST_IDLE) && start_i && !legal;
      case (state)
        ST_IDLE:  if (accept) state <= ST_ROUND;
        ST_ROUND: if (last)   state <= ST_DONE;
        default:              state <= ST_IDLE;
      endcase
    end
  end

  assign round_o    = (state == ST_ROUND) ? count : 4'd0;
  assign en_reg_o   = (state == ST_ROUND);
  assign sel_init_o = (state == ST_ROUND) && first;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = (state == ST_DONE);
  assign err_o      = err;

endmodule

// File: tb/tb_perm_ctrl.sv
// Bench for perm_ctrl: a timeline model (queue of expected per-cycle outputs)
// checked every cycle, plus literal expectations at key cycles.
module tb_perm_ctrl;

  localparam int RMAX = 12;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic [3:0] round;
  logic       sel_init, en_reg, busy, done, err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] round;
    logic       sel, en, busy, done, err;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  int   mdl_n;

  always #5 clk = ~clk;

  perm_ctrl #(.ROUNDS_MAX(RMAX)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .start_i    (start),
    .mode_i     (mode),
    .round_o    (round),
    .sel_init_o (sel_init),
    .en_reg_o   (en_reg),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  function automatic exp_t mk(input int r, input logic s, input logic e,
                              input logic b, input logic d, input logic x);
    exp_t v;
    v.round = 4'(r);
    v.sel = s; v.en = e; v.busy = b; v.done = d; v.err = x;
    return v;
  endfunction

  function automatic int rounds_of(input logic [1:0] m);
    case (m)
      2'b00: return 12;
      2'b01: return 6;
`ifdef ASCON_P8_EN
      2'b10: return 8;
`endif
      default: return 0;
    endcase
  endfunction

  // A start seen while not busy expands into the full expected timeline.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur <= '0;
    end else begin
      if (!cur.busy && start) begin
        mdl_n = rounds_of(mode);
        if (mdl_n == 0) q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        else begin
          for (int k = 0; k < mdl_n; k++)
            q.push_back(mk(RMAX - mdl_n + k, (k == 0), 1'b1, 1'b1, 1'b0, 1'b0));
          q.push_back(mk(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        end
      end
      if (q.size() != 0) cur <= q.pop_front();
      else               cur <= '0;
    end
  end

  task automatic cyc();
    @(negedge clk);
    checks++;
    if ({round, sel_init, en_reg, busy, done, err} !== cur) begin
      failures++;
      $display("FAIL model t=%0t got round=%0d sel=%b en=%b busy=%b done=%b err=%b want round=%0d sel=%b en=%b busy=%b done=%b err=%b",
               $time, round, sel_init, en_reg, busy, done, err,
               cur.round, cur.sel, cur.en, cur.busy, cur.done, cur.err);
    end
  endtask

  task automatic lit(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, expv);
    end
  endtask

  initial begin
    cyc(); cyc();
    lit("reset_outputs", int'({round, sel_init, en_reg, busy, done, err}), 0);
    rst = 1'b0;
    cyc();

    // p12
    start = 1'b1; mode = 2'b00;
    cyc();
    lit("p12_first_round", int'(round), 0);
    lit("p12_sel_init_first", int'(sel_init), 1);
    start = 1'b0;
    repeat (11) cyc();
    lit("p12_last_round", int'(round), 11);
    lit("p12_sel_init_low", int'(sel_init), 0);
    cyc();
    lit("p12_done", int'(done), 1);
    lit("p12_round_zero_done", int'(round), 0);
    cyc();
    lit("p12_busy_low", int'(busy), 0);

    // p6
    start = 1'b1; mode = 2'b01;
    cyc();
    lit("p6_first_round", int'(round), 6);
    start = 1'b0;
    repeat (5) cyc();
    lit("p6_last_round", int'(round), 11);
    cyc();
    lit("p6_done", int'(done), 1);
    cyc();

    // mode 10
    start = 1'b1; mode = 2'b10;
    cyc();
`ifdef ASCON_P8_EN
    lit("p8_first_round", int'(round), 4);
    start = 1'b0;
    repeat (7) cyc();
    lit("p8_last_round", int'(round), 11);
    cyc();
    lit("p8_done", int'(done), 1);
    cyc();
`else
    lit("p8_off_err", int'(err), 1);
    lit("p8_off_busy", int'(busy), 0);
    start = 1'b0;
    cyc();
    lit("p8_off_err_pulse", int'(err), 0);
`endif

    // mode 11
    start = 1'b1; mode = 2'b11;
    cyc();
    lit("illegal_err", int'(err), 1);
    lit("illegal_no_en", int'(en_reg), 0);
    start = 1'b0;
    cyc();
    lit("illegal_err_pulse", int'(err), 0);
    lit("illegal_busy", int'(busy), 0);

    // start held through a p6 run; mode changes mid-run must be ignored
    start = 1'b1; mode = 2'b01;
    cyc();
    mode = 2'b11;
    repeat (5) cyc();
    mode = 2'b01;
    cyc();
    lit("held_done", int'(done), 1);
    cyc();
    lit("held_idle_gap", int'(busy), 0);
    cyc();
    lit("held_restart_round", int'(round), 6);
    lit("held_restart_sel", int'(sel_init), 1);
    start = 1'b0;
    repeat (7) cyc();

    // reset mid-p12 at round 5
    start = 1'b1; mode = 2'b00;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    lit("abort_round_before", int'(round), 5);
    #2 rst = 1'b1;
    #1 lit("async_reset_outputs", int'({round, sel_init, en_reg, busy, done, err}), 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    lit("abort_not_resumed", int'(busy), 0);
    start = 1'b1; mode = 2'b01;
    cyc();
    lit("after_reset_p6_round", int'(round), 6);
    lit("after_reset_p6_sel", int'(sel_init), 1);
    start = 1'b0;
    repeat (5) cyc();
    cyc();
    lit("after_reset_p6_done", int'(done), 1);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
